// File: rtl/wheel_state_store.sv
// Double-buffered wheel node/velocity store: the updater streams a new state into the shadow set,
// and it is copied to the live set only once a complete, error-free step has been received.
module wheel_state_store #(
    parameter int NUM_NODES      = 8,
    parameter int POSITION_SIZE  = 16,
    parameter int VELOCITY_SIZE  = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                          clk_in,
    input  logic                                          rst_in,
    input  logic                                          step_in,
    input  logic                                          load_in,
    input  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]  init_nodes,
    input  logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]  init_velocities,
    output logic                                          begin_out,
    input  logic [POSITION_SIZE-1:0]                      node_in_x,
    input  logic [POSITION_SIZE-1:0]                      node_in_y,
    input  logic                                          node_in_valid,
    input  logic                                          node_in_done,
    input  logic [VELOCITY_SIZE-1:0]                      velocity_in_x,
    input  logic [VELOCITY_SIZE-1:0]                      velocity_in_y,
    input  logic                                          velocity_in_valid,
    input  logic                                          result_in,
    output logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]  nodes_out,
    output logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]  velocities_out,
    output logic                                          busy,
    output logic                                          step_done,
    output logic [1:0]                                    error_out,
    output logic [1:0]                                    state_dbg
);
    localparam int IW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int CW = $clog2(NUM_NODES) + 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_NODES, S_VELS, S_COMMIT} state_t;

    state_t state_q, state_d;
    logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] live_n_q, live_n_d, sh_n_q, sh_n_d;
    logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] live_v_q, live_v_d, sh_v_q, sh_v_d;
    logic [CW-1:0] node_cnt_q, node_cnt_d, vel_cnt_q, vel_cnt_d, n_after, v_after;
    logic [WW-1:0] wdog_q, wdog_d, wdog_nx;
    logic [1:0]    err_q, err_d;
    logic          step_err_q, step_err_d;
    logic          begin_q, begin_d, done_q, done_d, busy_q, busy_d;
    logic          e01, e10, e11, stray;

    always_comb begin
        state_d    = state_q;
        live_n_d   = live_n_q;
        live_v_d   = live_v_q;
        sh_n_d     = sh_n_q;
        sh_v_d     = sh_v_q;
        node_cnt_d = node_cnt_q;
        vel_cnt_d  = vel_cnt_q;
        wdog_d     = wdog_q;
        err_d      = err_q;
        step_err_d = step_err_q;
        begin_d    = 1'b0;
        done_d     = 1'b0;
        e01        = 1'b0;
        e10        = 1'b0;
        e11        = 1'b0;
        n_after    = node_cnt_q;
        v_after    = vel_cnt_q;
        wdog_nx    = wdog_q + WW'(1);
        stray      = node_in_valid | node_in_done | velocity_in_valid | result_in;

        case (state_q)
            S_IDLE: begin
                if (load_in) begin
                    live_n_d = init_nodes;
                    sh_n_d   = init_nodes;
                    live_v_d = init_velocities;
                    sh_v_d   = init_velocities;
                    err_d    = 2'b00;
                end else begin
                    e11 = stray;
                    if (step_in) begin
                        begin_d    = 1'b1;
                        node_cnt_d = '0;
                        vel_cnt_d  = '0;
                        wdog_d     = '0;
                        step_err_d = 1'b0;
                        state_d    = S_NODES;
                    end
                end
            end
            S_NODES: begin
                if (wdog_nx == WW'(TIMEOUT_CYCLES)) begin
                    e10     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdog_d = wdog_nx;
                    if (node_in_valid) begin
                        if (node_cnt_q < CW'(NUM_NODES)) begin
                            sh_n_d[0][node_cnt_q[IW-1:0]] = node_in_x;
                            sh_n_d[1][node_cnt_q[IW-1:0]] = node_in_y;
                            n_after = node_cnt_q + CW'(1);
                        end else begin
                            e01 = 1'b1;
                        end
                    end
                    node_cnt_d = n_after;
                    // The beat sharing the done cycle is already included in n_after.
                    if (node_in_done) begin
                        if (n_after != CW'(NUM_NODES)) e01 = 1'b1;
                        state_d = S_VELS;
                    end
                end
            end
            S_VELS: begin
                if (wdog_nx == WW'(TIMEOUT_CYCLES)) begin
                    e10     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdog_d = wdog_nx;
                    if (velocity_in_valid) begin
                        if (vel_cnt_q < CW'(NUM_NODES)) begin
                            sh_v_d[0][vel_cnt_q[IW-1:0]] = velocity_in_x;
                            sh_v_d[1][vel_cnt_q[IW-1:0]] = velocity_in_y;
                            v_after = vel_cnt_q + CW'(1);
                        end else begin
                            e01 = 1'b1;
                        end
                    end
                    vel_cnt_d = v_after;
                    if (result_in) begin
                        if (v_after == CW'(NUM_NODES) && !step_err_q && !e01) begin
                            state_d = S_COMMIT;
                        end else begin
                            e01     = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                live_n_d = sh_n_q;
                live_v_d = sh_v_q;
                done_d   = 1'b1;
                e11      = stray;
                state_d  = S_IDLE;
            end
        endcase

        step_err_d = step_err_d | e01 | e10;
        // Only the first error since load/reset is kept.
        if (err_q == 2'b00) begin
            if (e10)      err_d = 2'b10;
            else if (e01) err_d = 2'b01;
            else if (e11) err_d = 2'b11;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            live_n_q   <= '0;
            live_v_q   <= '0;
            sh_n_q     <= '0;
            sh_v_q     <= '0;
            node_cnt_q <= '0;
            vel_cnt_q  <= '0;
            wdog_q     <= '0;
            err_q      <= 2'b00;
            step_err_q <= 1'b0;
            begin_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            live_n_q   <= live_n_d;
            live_v_q   <= live_v_d;
            sh_n_q     <= sh_n_d;
            sh_v_q     <= sh_v_d;
            node_cnt_q <= node_cnt_d;
            vel_cnt_q  <= vel_cnt_d;
            wdog_q     <= wdog_d;
            err_q      <= err_d;
            step_err_q <= step_err_d;
            begin_q    <= begin_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign nodes_out      = live_n_q;
    assign velocities_out = live_v_q;
    assign begin_out      = begin_q;
    assign step_done      = done_q;
    assign busy           = busy_q;
    assign error_out      = err_q;
    assign state_dbg      = state_q;
endmodule
